// File: rtl/ps2_key_event_ctrl_if.sv
// Scancode byte input and key-event output handshake of the PS/2 key event controller.
// The slave side is the controller; the master side is the receiver/consumer pair.
interface ps2_key_event_ctrl_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;

    modport master (
        output byte_valid, byte_data, evt_ready,
        input  evt_valid, evt_code, evt_ext, evt_break
    );

    modport slave (
        input  byte_valid, byte_data, evt_ready,
        output evt_valid, evt_code, evt_ext, evt_break
    );
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scancode sequencer: E0/F0 prefix decode, held-key tracking with typematic
// suppression, press counting and a small event FIFO drained by valid/ready.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen
// S_BRK     | F0 seen
// S_EXT_BRK | E0 F0 seen
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    ps2_key_event_ctrl_if.slave  bus,
    output logic                 held_valid_o,
    output logic [7:0]           held_code_o,
    output logic                 held_ext_o,
    output logic [7:0]           press_count_o,
    output logic                 overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               held_valid_q, held_valid_d;
    logic [7:0]         held_code_q, held_code_d;
    logic               held_ext_q, held_ext_d;
    logic [7:0]         press_count_q, press_count_d;
    logic               overflow_q, overflow_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [9:0]         mem_q [FIFO_DEPTH];

    logic is_err;
    logic dec_fire, dec_ext, dec_brk;
    logic key_match, is_make, is_repeat, push, pop, full, push_ok;

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        dec_fire  = 1'b0;
        dec_ext   = 1'b0;
        dec_brk   = 1'b0;
        is_err    = (bus.byte_data == 8'h00) || (bus.byte_data == 8'hFF);
        if (bus.byte_valid) begin
            tmo_cnt_d = '0;
            if (is_err) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.byte_data == 8'hE0)      state_d = S_EXT;
                        else if (bus.byte_data == 8'hF0) state_d = S_BRK;
                        else                             dec_fire = 1'b1;
                    end
                    S_EXT: begin
                        if (bus.byte_data == 8'hF0)      state_d = S_EXT_BRK;
                        else if (bus.byte_data == 8'hE0) state_d = S_EXT;
                        else begin
                            dec_fire = 1'b1;
                            dec_ext  = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    S_BRK, S_EXT_BRK: begin
                        state_d = S_IDLE;
                        if (bus.byte_data != 8'hE0 && bus.byte_data != 8'hF0) begin
                            dec_fire = 1'b1;
                            dec_brk  = 1'b1;
                            dec_ext  = (state_q == S_EXT_BRK);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot corrupt the next key.
            if (tmo_cnt_q == TMO_LAST) begin
                state_d   = S_IDLE;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    always_comb begin
        key_match     = held_valid_q && (held_ext_q == dec_ext) && (held_code_q == bus.byte_data);
        is_make       = dec_fire && !dec_brk;
        is_repeat     = is_make && key_match;
        push          = dec_fire && !is_repeat;
        held_valid_d  = held_valid_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
        press_count_d = press_count_q;
        if (is_make && !key_match) begin
            held_valid_d  = 1'b1;
            held_code_d   = bus.byte_data;
            held_ext_d    = dec_ext;
            press_count_d = press_count_q + 8'd1;
        end else if (dec_fire && dec_brk && key_match) begin
            held_valid_d = 1'b0;
        end
    end

    always_comb begin
        pop        = (count_q != '0) && bus.evt_ready;
        full       = (count_q == DEPTH_C);
        push_ok    = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            tmo_cnt_q     <= '0;
            held_valid_q  <= 1'b0;
            held_code_q   <= '0;
            held_ext_q    <= 1'b0;
            press_count_q <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            held_valid_q  <= held_valid_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            press_count_q <= press_count_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage is cleared on reset so the head outputs read as zero afterwards.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= {dec_ext, dec_brk, bus.byte_data};
        end
    end

    assign bus.evt_valid = (count_q != '0);
    assign {bus.evt_ext, bus.evt_break, bus.evt_code} = mem_q[rd_ptr_q];

    assign held_valid_o  = held_valid_q;
    assign held_code_o   = held_code_q;
    assign held_ext_o    = held_ext_q;
    assign press_count_o = press_count_q;
    assign overflow_o    = overflow_q;

endmodule
